// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code step tracker: FSM states, direction codes
// and a 4-bit Gray-to-binary function.
package gray_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    TRACK = 3'd2,
    HOLD  = 3'd3,
    ERROR = 3'd4
  } state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int GRAY_W = 4;

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_bin_conv.sv
// Combinational WIDTH-bit Gray-to-binary converter.
module gray_bin_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b
);

  if (WIDTH == GRAY_W) begin : g_pkg_fn
    assign b = gray2bin(g);
  end else begin : g_generic
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign b[i] = ^g[WIDTH-1:i];
    end
  end

endmodule

// File: rtl/gray4_step_tracker.sv
// Stability-filtered Gray position tracker with +1/-1 step reporting over valid/ready.
// Optional macro GRAY_TRACK_ERR_RESYNC_EN: skips resync with a one-cycle err pulse instead of locking.
module gray4_step_tracker
  import gray_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int POS_W      = 16,
  parameter int STABLE_CYC = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] g_in,
  input  logic             step_ready,
  output logic             step_valid,
  output logic             step_dir,
  output logic [POS_W-1:0] pos,
  output logic [WIDTH-1:0] bin_out,
  output logic             err,
  output logic             busy
);

  localparam int              CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
  localparam logic [WIDTH-1:0] DELTA_UP = WIDTH'(1);
  localparam logic [WIDTH-1:0] DELTA_DN = {WIDTH{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             valid_q, valid_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] bin_s, bin_ref, delta;
  logic             stable, accept;

  gray_bin_conv #(.WIDTH(WIDTH)) u_conv_s   (.g(s_q),   .b(bin_s));
  gray_bin_conv #(.WIDTH(WIDTH)) u_conv_ref (.g(ref_q), .b(bin_ref));

  assign delta  = bin_s - bin_ref;
  assign stable = (cnt_q == CNT_MAX);
  // A pending step blocks new acceptance, so each event is handed over before the next.
  assign accept = stable && (s_q != ref_q) && !valid_q;

  // Input sampler and stability run-length counter
  always_comb begin
    s_d   = g_in;
    cnt_d = cnt_q;
    if (g_in != s_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Next-state, position, handshake and error logic
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    bin_d   = bin_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    valid_d = valid_q && !step_ready;
`ifdef GRAY_TRACK_ERR_RESYNC_EN
    err_d   = 1'b0;
`else
    err_d   = err_q;
`endif
    if (clr) begin
      state_d = INIT;
      pos_d   = '0;
      err_d   = 1'b0;
      valid_d = 1'b0;
    end else if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = INIT;
        INIT: begin
          if (stable) begin
            ref_d   = s_q;
            bin_d   = bin_s;
            state_d = TRACK;
          end else begin
            state_d = INIT;
          end
        end
        TRACK: begin
          if (accept && (delta == DELTA_UP || delta == DELTA_DN)) begin
            ref_d   = s_q;
            bin_d   = bin_s;
            valid_d = 1'b1;
            if (delta == DELTA_UP) begin
              pos_d = pos_q + POS_W'(1);
              dir_d = DIR_UP;
            end else begin
              pos_d = pos_q - POS_W'(1);
              dir_d = DIR_DN;
            end
            state_d = step_ready ? TRACK : HOLD;
          end else if (accept) begin
`ifdef GRAY_TRACK_ERR_RESYNC_EN
            ref_d   = s_q;
            bin_d   = bin_s;
            err_d   = 1'b1;
            state_d = TRACK;
`else
            err_d   = 1'b1;
            state_d = ERROR;
`endif
          end else begin
            state_d = TRACK;
          end
        end
        HOLD: begin
          if (valid_q && step_ready) begin
            state_d = TRACK;
          end else begin
            state_d = HOLD;
          end
        end
        ERROR:   state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == TRACK) || (state_d == HOLD);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
      ref_q   <= '0;
      bin_q   <= '0;
      pos_q   <= '0;
      valid_q <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      bin_q   <= bin_d;
      pos_q   <= pos_d;
      valid_q <= valid_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign step_valid = valid_q;
  assign step_dir   = dir_q;
  assign pos        = pos_q;
  assign bin_out    = bin_q;
  assign err        = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_gray4_step_tracker.sv
// Bench for gray4_step_tracker: directed scenarios then random walks, all checked against
// a cycle-level behavioural model built from integer arithmetic and a Gray lookup.
module tb_gray4_step_tracker;

  localparam int STAB = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  g_in = 4'd0;
  logic        step_ready = 1'b0;
  logic        step_valid, step_dir, err, busy;
  logic [15:0] pos;
  logic [3:0]  bin_out;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: last sample, its run length, reference code, outputs, mode
  int m_s, m_run, m_ref, m_bin, m_pos, m_mode;
  bit m_valid, m_dir, m_err;
  localparam int M_IDLE = 0, M_INIT = 1, M_TRACK = 2, M_HOLD = 3, M_ERR = 4;

  int cur_b;

  gray4_step_tracker #(.WIDTH(4), .POS_W(16), .STABLE_CYC(STAB)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .g_in(g_in),
    .step_ready(step_ready), .step_valid(step_valid), .step_dir(step_dir),
    .pos(pos), .bin_out(bin_out), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int bin2gray(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  function automatic int gray2bin_tb(input int g);
    for (int i = 0; i < 16; i++) begin
      if (bin2gray(i) == g) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_s = 0; m_run = 0; m_ref = 0; m_bin = 0; m_pos = 0; m_mode = M_IDLE;
    m_valid = 0; m_dir = 0; m_err = 0;
  endtask

  task automatic model_step(input int g, input bit e, input bit c, input bit r);
    bit stable_now, handshake;
    int next_run, d;
    stable_now = (m_run >= STAB);
    handshake  = m_valid && r;
    next_run   = (g != m_s) ? 1 : ((m_run < STAB) ? m_run + 1 : m_run);
`ifdef GRAY_TRACK_ERR_RESYNC_EN
    m_err = 0;
`endif
    if (c) begin
      m_mode = M_INIT; m_pos = 0; m_err = 0; m_valid = 0;
    end else begin
      if (handshake) m_valid = 0;
      if (!e) begin
        m_mode = M_IDLE;
      end else if (m_mode == M_IDLE) begin
        m_mode = M_INIT;
      end else if (m_mode == M_INIT) begin
        if (stable_now) begin
          m_ref = m_s; m_bin = gray2bin_tb(m_s); m_mode = M_TRACK;
        end
      end else if (m_mode == M_HOLD) begin
        if (handshake) m_mode = M_TRACK;
      end else if (m_mode == M_TRACK && stable_now && m_s != m_ref && !handshake && !m_valid) begin
        d = (gray2bin_tb(m_s) - m_bin + 16) % 16;
        if (d == 1 || d == 15) begin
          m_pos   = (d == 1) ? (m_pos + 1) % 65536 : (m_pos + 65535) % 65536;
          m_dir   = (d == 1);
          m_valid = 1;
          m_ref   = m_s; m_bin = gray2bin_tb(m_s);
          m_mode  = r ? M_TRACK : M_HOLD;
        end else begin
`ifdef GRAY_TRACK_ERR_RESYNC_EN
          m_ref = m_s; m_bin = gray2bin_tb(m_s); m_err = 1;
`else
          m_err = 1; m_mode = M_ERR;
`endif
        end
      end
    end
    m_s = g; m_run = next_run;
  endtask

  task automatic check_all();
    chk("step_valid", step_valid, m_valid);
    chk("step_dir", step_dir, m_dir);
    chk("pos", pos, m_pos);
    chk("bin_out", bin_out, m_bin);
    chk("err", err, m_err);
    chk("busy", busy, (m_mode == M_TRACK || m_mode == M_HOLD));
  endtask

  // one clock: drive at the falling edge, step the model at the rising edge, compare next fall
  task automatic cyc(input logic [3:0] g, input bit e, input bit c, input bit r);
    g_in = g; en = e; clr = c; step_ready = r;
    @(posedge clk);
    model_step(int'(g), e, c, r);
    @(negedge clk);
    check_all();
  endtask

  task automatic hold_code(input logic [3:0] g, input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(g, 1'b1, 1'b0, r);
  endtask

  initial begin
    logic [3:0] gcode;
    int r, len;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", step_valid, 0);
    chk("rst_pos", pos, 0);
    chk("rst_bin", bin_out, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // bring-up: INIT then TRACK on code 0
    hold_code(4'b0000, 6, 1'b1);
    chk("init_busy", busy, 1);
    chk("init_pos", pos, 0);

    // three up steps
    hold_code(4'b0001, 4, 1'b1);
    hold_code(4'b0011, 4, 1'b1);
    hold_code(4'b0010, 4, 1'b1);
    hold_code(4'b0010, 2, 1'b1);
    chk("up_pos", pos, 3);
    chk("up_bin", bin_out, 3);

    // back to 0, then down across the 15/0 boundary
    hold_code(4'b0011, 4, 1'b1);
    hold_code(4'b0001, 4, 1'b1);
    hold_code(4'b0000, 4, 1'b1);
    hold_code(4'b1000, 4, 1'b1);
    hold_code(4'b1001, 4, 1'b1);
    chk("dn_pos", pos, 16'hFFFE);
    chk("dn_dir", step_dir, 0);
    hold_code(4'b1000, 4, 1'b1);
    hold_code(4'b0000, 5, 1'b1);
    chk("wrap_pos", pos, 0);

    // stalled consumer: second step waits for the handshake
    hold_code(4'b0001, 4, 1'b0);
    hold_code(4'b0011, 5, 1'b0);
    chk("hold_valid", step_valid, 1);
    chk("hold_pos", pos, 1);
    hold_code(4'b0011, 4, 1'b1);
    chk("hold_pos2", pos, 2);

    // short glitches are filtered out
    hold_code(4'b0010, 1, 1'b1);
    hold_code(4'b0011, 1, 1'b1);
    hold_code(4'b0110, 2, 1'b1);
    hold_code(4'b0011, 5, 1'b1);
    chk("glitch_pos", pos, 2);

    // skip of two codes
    hold_code(4'b0001, 4, 1'b1);
    hold_code(4'b0000, 4, 1'b1);
    hold_code(4'b0011, 4, 1'b1);
    chk("skip_err", err, 1);
    chk("skip_pos", pos, 0);
`ifdef GRAY_TRACK_ERR_RESYNC_EN
    chk("skip_bin", bin_out, 2);
`endif
    hold_code(4'b0011, 2, 1'b1);
    cyc(4'b0011, 1'b1, 1'b1, 1'b1);
    chk("clr_err", err, 0);
    chk("clr_pos", pos, 0);
    hold_code(4'b0011, 5, 1'b1);

    // async reset while a step is held
    hold_code(4'b0010, 5, 1'b0);
    chk("prereset_valid", step_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("areset_valid", step_valid, 0);
    chk("areset_pos", pos, 0);
    chk("areset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cur_b = 0;
    hold_code(4'b0000, 6, 1'b1);

    // random walk with stalls, occasional skips, clears and disables
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) cur_b = (cur_b + 1) % 16;
      else if (r < 8) cur_b = (cur_b + 15) % 16;
      else if (r == 8) cur_b = $urandom_range(0, 15);
      gcode = 4'(bin2gray(cur_b));
      len = $urandom_range(1, 5);
      for (int j = 0; j < len; j++) begin
        cyc(gcode, ($urandom_range(0, 59) != 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 2) != 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gray4_step_tracker.md
# gray4_step_tracker

Sequencing controller around the team's 4-bit Gray-to-binary converter. It samples a Gray-coded position input, such as an encoder or a pointer bus, and filters it for stability. Each accepted value is converted to binary and classified as a +1 step, a -1 step or an illegal skip. The block keeps a wrapping position count and reports each step to a downstream consumer over a valid/ready handshake.

## Interface
- WIDTH, 4: Gray input width.
- POS_W, 16: position counter width.
- STABLE_CYC, 3: consecutive cycles a new code must hold before acceptance (range 1..15).

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  tracking enable; low forces IDLE
- clr  in  1  synchronous clear: pos=0, err=0, state→INIT
- g_in  in  WIDTH  Gray-coded input
- step_ready  in  1  consumer accepts step event
- step_valid  out  1  step event pending
- step_dir  out  1  1 = up (+1), 0 = down (-1); valid with step_valid
- pos  out  POS_W  signed-agnostic position count, wraps mod 2^POS_W
- bin_out  out  WIDTH  binary of last accepted code (registered)
- err  out  1  skip error flag
- busy  out  1  state is TRACK or HOLD

## Operation
- The input register samples g_in every cycle: s <= g_in.
- The stability counter resets to 1 when s changes and saturates at STABLE_CYC.
- A candidate is accepted when the counter reaches STABLE_CYC and s differs from ref, where ref is the last accepted Gray code.
- delta = gray2bin(s) - gray2bin(ref), computed mod 2^WIDTH:
  - delta 1: pos+1, step_dir=1, step_valid=1.
  - delta 2^WIDTH-1: pos-1, step_dir=0, step_valid=1.
  - any other nonzero delta: skip error.
- States:
  - IDLE: en=0. Outputs hold; no acceptance.
  - INIT: entered when en rises or clr is asserted. The first stable value loads ref and bin_out. No step and no pos change. → TRACK.
  - TRACK: normal acceptance. A step goes to HOLD when step_ready=0; on an immediate handshake it stays in TRACK.
  - HOLD: step_valid held with step_dir and pos stable. Acceptance is stalled; the filter keeps running. step_ready=1 → TRACK.
  - ERROR: err=1, pos frozen. Leaves only on clr (→ INIT) or en=0 (→ IDLE, err stays set).
- Priority, highest first: rst_n, clr, en low, normal operation.
- On acceptance, ref and bin_out update in the same edge as pos.

## Timing
- Reset values: step_valid=0, step_dir=0, pos=0, bin_out=0, err=0, busy=0, state=IDLE, ref=0, stability counter=0.
- Latency: if g_in is stable from edge N, the value is accepted at edge N+STABLE_CYC. pos, bin_out and step_valid are visible after that edge.
- step_valid rises with the pos update. It falls on the edge where step_valid & step_ready is sampled high.
- After a handshake, the earliest next acceptance is the following edge, provided the new code is already stable.
- A glitch shorter than STABLE_CYC cycles is never accepted; pos is unchanged.
- pos wraps: 2^POS_W-1 + 1 → 0, and 0 - 1 → 2^POS_W-1.
- ref wraps at the Gray boundary: 1000 ↔ 0000 (binary 15 ↔ 0) is a legal ±1 step.
- clr and acceptance on the same edge: clr wins and no step is produced.
- If clr arrives during HOLD, step_valid drops next edge without a handshake.
- Reset asserted mid-HOLD drops all outputs immediately (asynchronous).

## Configuration
- GRAY_TRACK_ERR_RESYNC_EN:
  - Defined: a skip error does not enter ERROR. ref and bin_out resync to the new code, pos is unchanged, err pulses high for one cycle, and the state stays TRACK.
  - Undefined: a skip error enters the sticky ERROR state as described above.

## Structure
- The shared package gray_pkg holds:
  - the state enum (IDLE, INIT, TRACK, HOLD, ERROR);
  - the function gray2bin(g);
  - the constants DIR_UP=1 and DIR_DN=0.
- Sub-module gray_bin_conv is the combinational WIDTH-bit Gray→binary converter, instantiated twice: once for s and once for ref.
- Top level holds the input register, the stability counter, the FSM, the pos counter and the handshake register.

## Test plan
- Reset, en=1, g_in=0000 held 3 cycles → INIT, then TRACK with bin_out=0000, pos=0 and no step_valid.
- Gray sequence 0000→0001→0011→0010, each held 4 cycles, step_ready=1 → three up steps, pos=3, bin_out=0011.
- From bin 0 apply g_in=1000 (bin 15), then 1001 (bin 14) → two down steps, pos=0xFFFE, step_dir=0.
- Up step with step_ready=0 for 5 cycles, then g_in moves +1 → step_valid held with pos unchanged. After ready, the second step is accepted, giving pos +2 in total.
- From 0000 apply 0011 (bin 2) → without the macro: err=1, state ERROR, pos frozen; clr → err=0, pos=0. With the macro: a one-cycle err pulse and bin_out=0010.
- 1-cycle and 2-cycle glitches on g_in with STABLE_CYC=3 → no acceptance and no step.
